// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the MIPS pipeline: bus widths, register count and
// enable encodings used by the decode and write-back stages.
package regfile_pkg;

   localparam int unsigned RegBus     = 32;
   localparam int unsigned RegAddrBus = 5;
   localparam int unsigned RegNum     = 32;
   localparam int unsigned CntW       = 32;

   localparam logic [RegBus-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBus-1:0] NopRegAddr = '0;

   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic ReadEnable   = 1'b1;
   localparam logic ReadDisable  = 1'b0;
   localparam logic RstEnable    = 1'b1;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational register-file read port: reset, r0, enable, write-bypass, then storage.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = RegBus,
   parameter int unsigned ADDR_W = RegAddrBus,
   parameter int unsigned NREGS  = RegNum
) (
   input  logic              rst,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] regs [NREGS],
   output logic [DATA_W-1:0] rdata
);

   always_comb begin
      rdata = '0;
      if (rst == RstEnable) begin
         rdata = '0;
      end else if (raddr == '0) begin
         rdata = '0;
      end else if (re == ReadDisable) begin
         rdata = '0;
      end else if (we == WriteEnable && waddr == raddr) begin
         rdata = wdata;
      end else if (32'(raddr) < NREGS) begin
         rdata = regs[raddr];
      end
   end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: one write port, two bypassed read ports, a debug read port
// and a committed-write counter.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = RegBus,
   parameter int unsigned ADDR_W = RegAddrBus,
   parameter int unsigned NREGS  = RegNum,
   parameter int unsigned CNT_W  = CntW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_cnt
);

   logic [DATA_W-1:0] reg_view [NREGS];
   logic              commit;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign commit      = (we == WriteEnable) && (waddr != '0);
   assign reg_view[0] = '0;

   // Index 0 has no flop; its view entry is a constant zero.
   for (genvar i = 1; i < NREGS; i++) begin : g_reg
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk) begin
         if (rst == RstEnable) begin
            q <= '0;
         end else if (commit && waddr == ADDR_W'(i)) begin
            q <= wdata;
         end
      end
      assign reg_view[i] = q;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (commit) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign wr_cnt = cnt_q;

   regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd1 (
      .rst   (rst),
      .re    (re1),
      .raddr (raddr1),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .regs  (reg_view),
      .rdata (rdata1)
   );

   regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd2 (
      .rst   (rst),
      .re    (re2),
      .raddr (raddr2),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .regs  (reg_view),
      .rdata (rdata2)
   );

   regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd_dbg (
      .rst   (rst),
      .re    (ReadEnable),
      .raddr (dbg_addr),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .regs  (reg_view),
      .rdata (dbg_data)
   );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected read/counter values, a negedge
// monitor compares them against a full-width DUT and a 4-bit-counter DUT.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst, we, re1, re2;
   logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata2, dbg_data, wr_cnt;
   logic [31:0] rdata1_s, rdata2_s, dbg_data_s;
   logic [3:0]  wr_cnt_s;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      string       name;
      bit          c1;
      logic [31:0] e1;
      bit          c2;
      logic [31:0] e2;
      bit          cd;
      logic [31:0] ed;
      bit          cc;
      logic [31:0] ec;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   regfile u_dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .wr_cnt   (wr_cnt)
   );

   regfile #(.CNT_W(4)) u_dut_s (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1_s),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2_s),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data_s),
      .wr_cnt   (wr_cnt_s)
   );

   function automatic void cmp(string n, logic [31:0] act, logic [31:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", n, act, req);
      end
   endfunction

   // Monitor: everything queued during a cycle is checked mid-cycle, away from the edge.
   exp_t m;
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         m = sb_q.pop_front();
         if (m.c1) begin
            cmp({m.name, ".rdata1"}, rdata1, m.e1);
            cmp({m.name, ".rdata1_s"}, rdata1_s, m.e1);
         end
         if (m.c2) begin
            cmp({m.name, ".rdata2"}, rdata2, m.e2);
            cmp({m.name, ".rdata2_s"}, rdata2_s, m.e2);
         end
         if (m.cd) begin
            cmp({m.name, ".dbg_data"}, dbg_data, m.ed);
            cmp({m.name, ".dbg_data_s"}, dbg_data_s, m.ed);
         end
         if (m.cc) begin
            cmp({m.name, ".wr_cnt"}, wr_cnt, m.ec);
            cmp({m.name, ".wr_cnt_s"}, {28'd0, wr_cnt_s}, {28'd0, m.ec[3:0]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(string n, bit c1, logic [31:0] e1, bit c2, logic [31:0] e2,
                       bit cd, logic [31:0] ed, bit cc, logic [31:0] ec);
      exp_t e;
      e.name = n; e.c1 = c1; e.e1 = e1; e.c2 = c2; e.e2 = e2;
      e.cd = cd; e.ed = ed; e.cc = cc; e.ec = ec;
      sb_q.push_back(e);
   endtask

   task automatic rd(logic r1, logic [4:0] a1, logic r2, logic [4:0] a2, logic [4:0] ad);
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2; dbg_addr = ad;
   endtask

   task automatic wr(logic w, logic [4:0] a, logic [31:0] d);
      we = w; waddr = a; wdata = d;
   endtask

   initial begin
      rst = 1'b1;
      wr(1'b0, 5'd0, 32'd0);
      rd(1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
      step();
      push("rst_hold", 1, 32'd0, 1, 32'd0, 1, 32'd0, 1, 32'd0);
      step();
      rst = 1'b0;

      // Reset state: every register reads zero on both ports and debug.
      for (int i = 1; i < 32; i++) begin
         rd(1'b1, 5'(i), 1'b1, 5'(i), 5'(i));
         push($sformatf("reset_r%0d", i), 1, 32'd0, 1, 32'd0, 1, 32'd0, 1, 32'd0);
         step();
      end

      // Basic write then read.
      rd(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      wr(1'b1, 5'd5, 32'h1234ABCD);
      step();
      wr(1'b0, 5'd0, 32'd0);
      rd(1'b1, 5'd5, 1'b1, 5'd6, 5'd5);
      push("basic", 1, 32'h1234ABCD, 1, 32'd0, 1, 32'h1234ABCD, 1, 32'd1);
      step();

      // Bypass on all three ports, then from storage.
      wr(1'b1, 5'd7, 32'hDEADBEEF);
      rd(1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
      push("bypass", 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'd1);
      step();
      wr(1'b0, 5'd0, 32'd0);
      push("bypass_st", 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'd2);
      step();

      // r0 protection.
      wr(1'b1, 5'd0, 32'hFFFFFFFF);
      rd(1'b1, 5'd0, 1'b1, 5'd5, 5'd0);
      push("r0_wr", 1, 32'd0, 1, 32'h1234ABCD, 1, 32'd0, 1, 32'd2);
      step();
      wr(1'b0, 5'd0, 32'd0);
      push("r0_after", 1, 32'd0, 0, 32'd0, 1, 32'd0, 1, 32'd2);
      step();

      // Read-enable gating; debug is always enabled. Bypass is gated too.
      wr(1'b1, 5'd3, 32'h55);
      rd(1'b0, 5'd3, 1'b0, 5'd3, 5'd3);
      push("gate_byp", 1, 32'd0, 1, 32'd0, 1, 32'h55, 1, 32'd2);
      step();
      wr(1'b0, 5'd0, 32'd0);
      push("gate_off", 1, 32'd0, 1, 32'd0, 1, 32'h55, 1, 32'd3);
      step();
      rd(1'b0, 5'd3, 1'b1, 5'd3, 5'd7);
      push("gate_on", 1, 32'd0, 1, 32'h55, 1, 32'hDEADBEEF, 1, 32'd3);
      step();

      // Reset mid-operation with a colliding write.
      wr(1'b1, 5'd9, 32'hA5A5A5A5);
      rd(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      step();
      wr(1'b0, 5'd0, 32'd0);
      rd(1'b1, 5'd9, 1'b1, 5'd5, 5'd9);
      push("pre_rst", 1, 32'hA5A5A5A5, 1, 32'h1234ABCD, 1, 32'hA5A5A5A5, 1, 32'd4);
      step();
      rst = 1'b1;
      wr(1'b1, 5'd9, 32'h1);
      push("in_rst", 1, 32'd0, 1, 32'd0, 1, 32'd0, 1, 32'd4);
      step();
      rst = 1'b0;
      wr(1'b0, 5'd0, 32'd0);
      push("post_rst", 1, 32'd0, 1, 32'd0, 1, 32'd0, 1, 32'd0);
      step();

      // 16 commits: the 4-bit counter wraps to zero while the 32-bit one reaches 16.
      for (int i = 0; i < 16; i++) begin
         wr(1'b1, 5'((i % 15) + 1), 32'h100 + 32'(i));
         rd(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
         push($sformatf("wrap_%0d", i), 0, 32'd0, 0, 32'd0, 0, 32'd0, 1, 32'(i));
         step();
      end
      wr(1'b0, 5'd0, 32'd0);
      rd(1'b1, 5'd1, 1'b1, 5'd2, 5'd15);
      push("wrap_end", 1, 32'h10F, 1, 32'h101, 1, 32'h10E, 1, 32'd16);
      step();
      step();

      n_total++;
      if (sb_q.size() != 0) begin
         $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      end else begin
         n_pass++;
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
